instruction_loader: RTL and testbench



---
 rtl/instruction_loader_if.sv | 27 ++
 rtl/instruction_loader.sv | 117 +++++++++++
 tb/tb_instruction_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// The master side feeds bytes and start; the slave side (the loader) drives the write port.
interface instruction_loader_if #(
    parameter int NB_BYTE = 8,
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
);
    logic               i_start;
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_write_enable;
    logic [NB_ADDR-1:0] o_write_addr;
    logic [NB_DATA-1:0] o_write_data;
    logic               o_loading;
    logic               o_done;
    logic [NB_ADDR-1:0] o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_write_enable, o_write_addr, o_write_data, o_loading, o_done, o_word_count
    );
endinterface

// File: rtl/instruction_loader.sv
// Assembles little-endian byte groups into instructions and writes them to
// consecutive word addresses until HALT or the memory is full.
module instruction_loader #(
    parameter int                 NB_BYTE      = 8,
    parameter int                 NB_DATA      = 32,
    parameter int                 NB_ADDR      = 32,
    parameter int                 MEMORY_DEPTH = 64,
    parameter logic [NB_DATA-1:0] HALT_INSTR   = 32'hFFFFFFFF
) (
    input logic                 i_clock,
    input logic                 i_reset,
    instruction_loader_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for start, bytes ignored
    // RECEIVE | collecting bytes of the current word
    // WRITE   | one cycle issuing the assembled word to memory
    // DONE    | HALT seen or memory full, bytes ignored
    typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_e;

    localparam int NB_LANES = NB_DATA / NB_BYTE;

    state_e             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [NB_DATA-1:0] asm_q, asm_d;
    logic [NB_ADDR-1:0] count_q, count_d;
    logic               we_q, we_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               loading_q, loading_d;
    logic               done_q, done_d;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d    = RECEIVE;
                    byte_idx_d = 2'd0;
                    asm_d      = '0;
                    count_d    = '0;
                end
            end
            RECEIVE: begin
                if (bus.i_rx_valid) begin
                    for (int l = 0; l < NB_LANES; l++) begin
                        if (byte_idx_q == 2'(l)) begin
                            asm_d[l*NB_BYTE +: NB_BYTE] = bus.i_rx_data;
                        end
                    end
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                we_d    = 1'b1;
                addr_d  = count_q;
                data_d  = asm_q;
                count_d = count_q + NB_ADDR'(1);
                if ((asm_q == HALT_INSTR) || (count_q == NB_ADDR'(MEMORY_DEPTH - 1))) begin
                    state_d = DONE;
                end else begin
                    state_d = RECEIVE;
                    // A byte landing in the write cycle starts the next word so full line rate loses nothing.
                    if (bus.i_rx_valid) begin
                        asm_d[NB_BYTE-1:0] = bus.i_rx_data;
                        byte_idx_d         = 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        loading_d = (state_d == RECEIVE) || (state_d == WRITE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_write_enable = we_q;
    assign bus.o_write_addr   = addr_q;
    assign bus.o_write_data   = data_q;
    assign bus.o_loading      = loading_q;
    assign bus.o_done         = done_q;
    assign bus.o_word_count   = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a word-level model of the load sequence
// is checked against the DUT every cycle, plus literal expectations per scenario.
module tb_instruction_loader;
    localparam int          NB_BYTE = 8;
    localparam int          NB_DATA = 32;
    localparam int          NB_ADDR = 32;
    localparam int          DEPTH   = 64;
    localparam logic [31:0] HALT    = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_loader_if #(.NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    instruction_loader #(
        .NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR),
        .MEMORY_DEPTH(DEPTH), .HALT_INSTR(HALT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // model: bytes buffered per word, a completed word waiting to be written, load progress
    logic [7:0]  m_buf[$];
    bit          m_active, m_finished, m_have_word, m_we;
    logic [31:0] m_word, m_count, m_addr, m_data;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_buf.delete();
            m_active = 0; m_finished = 0; m_have_word = 0; m_we = 0;
            m_word = 0; m_count = 0; m_addr = 0; m_data = 0;
        end else begin
            m_we = 0;
            if (m_have_word) begin
                m_we = 1; m_addr = m_count; m_data = m_word;
                m_count = m_count + 1;
                m_have_word = 0;
                if (m_word == HALT || m_count == DEPTH) begin
                    m_active = 0; m_finished = 1;
                end else if (bus.i_rx_valid) begin
                    m_buf.push_back(bus.i_rx_data);
                end
            end else if (m_active) begin
                if (bus.i_rx_valid) m_buf.push_back(bus.i_rx_data);
                if (m_buf.size() == 4) begin
                    m_word = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                    m_have_word = 1;
                    m_buf.delete();
                end
            end else if (bus.i_start) begin
                m_active = 1; m_finished = 0; m_count = 0;
                m_buf.delete();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("write_enable", 32'(bus.o_write_enable), 32'(m_we));
        chk("write_addr", bus.o_write_addr, m_addr);
        chk("write_data", bus.o_write_data, m_data);
        chk("loading", 32'(bus.o_loading), 32'(m_active));
        chk("done", 32'(bus.o_done), 32'(m_finished));
        chk("word_count", bus.o_word_count, m_count);
        if (bus.o_write_enable) begin
            wr_addr.push_back(bus.o_write_addr);
            wr_data.push_back(bus.o_write_data);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        step();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_write(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr.size()) begin
            chk({name, "_addr"}, wr_addr[idx], a);
            chk({name, "_data"}, wr_data[idx], d);
        end else begin
            chk({name, "_present"}, 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_we"}, 32'(bus.o_write_enable), 0);
        chk({name, "_addr"}, bus.o_write_addr, 0);
        chk({name, "_data"}, bus.o_write_data, 0);
        chk({name, "_loading"}, 32'(bus.o_loading), 0);
        chk({name, "_done"}, 32'(bus.o_done), 0);
        chk({name, "_count"}, bus.o_word_count, 0);
    endtask

    initial begin
        logic [7:0]  t1_bytes[16];
        logic [31:0] t1_data[4];
        t1_bytes = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00,
                     8'h1E, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        t1_data  = '{32'h0000000A, 32'h00000014, 32'h0000001E, 32'hFFFFFFFF};

        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data = '0;
        do_reset();
        chk_zero_outputs("reset");

        // bytes while idle
        clear_log();
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        idle(2);
        chk("idle_bytes_nwrites", 32'(wr_addr.size()), 0);

        // three words then HALT, one idle cycle between bytes
        start();
        foreach (t1_bytes[i]) begin
            send(t1_bytes[i]);
            idle(1);
        end
        idle(2);
        chk("halt_nwrites", 32'(wr_addr.size()), 4);
        for (int i = 0; i < 4; i++) chk_write("halt_wr", i, 32'(i), t1_data[i]);
        chk("halt_done", 32'(bus.o_done), 1);
        chk("halt_count", bus.o_word_count, 4);
        chk("halt_loading", 32'(bus.o_loading), 0);

        // bytes while done
        clear_log();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        chk("done_bytes_nwrites", 32'(wr_addr.size()), 0);

        // restart from DONE, byte order and write latency
        start();
        chk("restart_count", bus.o_word_count, 0);
        chk("restart_done", 32'(bus.o_done), 0);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("lat_early_we", 32'(bus.o_write_enable), 0);
        idle(1);
        chk("lat_we", 32'(bus.o_write_enable), 1);
        chk("lat_addr", bus.o_write_addr, 0);
        chk("lat_data", bus.o_write_data, 32'h12345678);
        chk("lat_count", bus.o_word_count, 1);
        idle(1);
        chk("lat_we_drop", 32'(bus.o_write_enable), 0);

        // start during RECEIVE is ignored; then back-to-back bytes across a write cycle
        clear_log();
        send(8'h11); send(8'h22);
        start();
        send(8'h33); send(8'h44);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        chk("b2b_nwrites", 32'(wr_addr.size()), 3);
        chk_write("rx_start_wr", 0, 1, 32'h44332211);
        chk_write("b2b_wr0", 1, 2, 32'hDDCCBBAA);
        chk_write("b2b_wr1", 2, 3, 32'h04030201);
        chk("b2b_count", bus.o_word_count, 4);

        // reset mid-word, then reload from address 0
        do_reset();
        start();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        do_reset();
        chk_zero_outputs("midword_reset");
        clear_log();
        start();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        chk("reload_nwrites", 32'(wr_addr.size()), 1);
        chk_write("reload_wr", 0, 0, 32'h04030201);

        // fill the whole memory without HALT, then extra bytes
        do_reset();
        clear_log();
        start();
        for (int i = 0; i < 4 * DEPTH; i++) send(8'(i));
        send(8'hA5); send(8'h5A); send(8'hA5); send(8'h5A);
        idle(3);
        chk("fill_nwrites", 32'(wr_addr.size()), DEPTH);
        chk_write("fill_first", 0, 0, 32'h03020100);
        chk_write("fill_last", DEPTH - 1, DEPTH - 1, 32'hFFFEFDFC);
        chk("fill_done", 32'(bus.o_done), 1);
        chk("fill_count", bus.o_word_count, DEPTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
